div_rsub: RTL and testbench

Sequential unsigned divider using repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier and shares the same operand-loading style: a single `start` pulse, then dividend and divisor presented on consecutive cycles over one shared `data_in` bus. It returns quotient and remainder with a held `done` flag. Datapath and controller live in one module.

---
 rtl/div_rsub.sv | 107 ++++++++++
 tb/tb_div_rsub.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div_rsub.sv
// Sequential unsigned divider by repeated subtraction; dividend and divisor
// arrive on consecutive cycles over data_in after a start pulse.
module div_rsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [2:0] {
      IDLE,
      LDA,
      LDB,
      CHK,
      SUB,
      DONE
   } state_t;

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] div_q;
   logic             dbz_q;
   logic [WIDTH:0]   diff_d;

   // One extra bit so the lookahead exit compare sees the full difference.
   always_comb begin
      diff_d = {1'b0, rem_q} - {1'b0, div_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= LDA;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            LDA: begin
               rem_q   <= data_in;
               state_q <= LDB;
            end
            LDB: begin
               div_q   <= data_in;
               quo_q   <= '0;
               dbz_q   <= 1'b0;
               state_q <= CHK;
            end
            CHK: begin
               if (div_q == '0) begin
                  dbz_q   <= 1'b1;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (rem_q < div_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= SUB;
               end
            end
            SUB: begin
               rem_q <= diff_d[WIDTH-1:0];
               quo_q <= quo_q + 1'b1;
               // Leave as soon as the new remainder is already below the divisor.
               if (diff_d < {1'b0, div_q}) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_rsub.sv
// Self-checking bench for div_rsub: directed corner cases plus random
// divisions checked against plain integer division and modulo.
module tb_div_rsub;

   localparam int WIDTH = 16;
   localparam int EDGE_LIMIT = 70000;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks;
   int failures;
   int lastQ;
   int lastR;

   div_rsub #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .data_in     (data_in),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Runs one full division and checks results, latency and the busy/done relation.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input bit pulseStart, input string tag);
      int expQ;
      int expR;
      int expLat;
      int edgeIdx;
      bit busyOk;
      expQ   = (b == 0) ? 0 : int'(a) / int'(b);
      expR   = (b == 0) ? int'(a) : int'(a) % int'(b);
      expLat = 3 + expQ;

      @(negedge clk);
      start   = 1'b1;
      data_in = WIDTH'($urandom);
      @(negedge clk);
      start   = 1'b0;
      data_in = a;
      checkOutput({tag, "_E0_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_E0_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_E0_holdQ"}, 32'(quotient), lastQ);
      checkOutput({tag, "_E0_holdR"}, 32'(remainder), lastR);
      @(negedge clk);
      data_in = b;
      checkOutput({tag, "_E1_dividend"}, 32'(remainder), 32'(a));
      @(negedge clk);
      data_in = WIDTH'($urandom);
      checkOutput({tag, "_E2_qclear"}, 32'(quotient), 32'd0);

      edgeIdx = 2;
      busyOk  = 1'b1;
      while (done !== 1'b1 && edgeIdx < EDGE_LIMIT) begin
         start = pulseStart ? 1'($urandom_range(1, 0)) : 1'b0;
         @(negedge clk);
         edgeIdx++;
         if (busy !== !done) busyOk = 1'b0;
      end
      start = 1'b0;

      checkOutput({tag, "_latency"}, edgeIdx, expLat);
      checkOutput({tag, "_busyTrack"}, 32'(busyOk), 32'd1);
      checkOutput({tag, "_quotient"}, 32'(quotient), expQ);
      checkOutput({tag, "_remainder"}, 32'(remainder), expR);
      checkOutput({tag, "_dbz"}, 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
      lastQ = expQ;
      lastR = expR;
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      checks   = 0;
      failures = 0;
      lastQ    = 0;
      lastR    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      data_in  = '0;

      #12;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_q", 32'(quotient), 32'd0);
      checkOutput("reset_r", 32'(remainder), 32'd0);
      checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(16'd100, 16'd7, 1'b0, "d100_7");
      applyStimulus(16'd10, 16'd6, 1'b0, "d10_6");
      applyStimulus(16'd5, 16'd9, 1'b0, "d5_9");
      applyStimulus(16'd1234, 16'd0, 1'b0, "d1234_0");
      applyStimulus(16'd20, 16'd5, 1'b0, "d20_5");
      applyStimulus(16'd65535, 16'd65535, 1'b0, "dmax_max");
      applyStimulus(16'd100, 16'd7, 1'b1, "d100_7_pulsed");

      // Divisors kept large so random quotients (and run time) stay small.
      for (int i = 0; i < 8; i++) begin
         ra = WIDTH'($urandom);
         rb = (i == 3) ? '0 : WIDTH'($urandom_range(65535, 256));
         applyStimulus(ra, rb, 1'($urandom_range(1, 0)), $sformatf("rand%0d", i));
      end

      applyStimulus(16'd65535, 16'd1, 1'b0, "dmax_1");

      // Abort a division mid-SUB with an asynchronous reset between edges.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      data_in = 16'd100;
      @(negedge clk);
      data_in = 16'd7;
      repeat (6) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_q", 32'(quotient), 32'd0);
      checkOutput("abort_r", 32'(remainder), 32'd0);
      checkOutput("abort_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
      lastQ = 0;
      lastR = 0;
      applyStimulus(16'd9, 16'd3, 1'b0, "d9_3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
